// File: rtl/ddfs_pkg.sv
// ddfs_pkg: shared definitions for the DDFS phase controller slice.
//   ddfs_state_e    : controller state encoding (IDLE/TONE/SWEEP)
//   DEF_PHASE_BITS  : default phase accumulator / FTW width
//   DEF_LUT_DEPTH   : default ROM address width
//   REF_VALID_DLY   : tick-to-valid delay matching the registered ROM read
package ddfs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TONE  = 2'd1,
    SWEEP = 2'd2
  } ddfs_state_e;

  localparam int unsigned DEF_PHASE_BITS = 32;
  localparam int unsigned DEF_LUT_DEPTH  = 10;

  // One cycle for the address register, one for the ROM's registered read.
  localparam int unsigned REF_VALID_DLY  = 2;

endpackage

// File: rtl/ddfs_phase_acc.sv
// ddfs_phase_acc: phase accumulator, ROM address generation and the
// sample-valid / wrap delay line aligned with the ROM output.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : force accumulator to 0 (start / stop / idle)
//   advance       : take one sample this cycle
//   ftw           : frequency tuning word applied on this sample
//   phase_offset  : added to the truncated phase to form the ROM address
//   lut_addr      : registered ROM address, holds when not advancing
//   ref_valid     : ROM output is a valid sample this cycle
//   phase_wrap    : accumulator carried out on the sample now valid
module ddfs_phase_acc
  import ddfs_pkg::*;
#(
  parameter int unsigned PHASE_BITS = DEF_PHASE_BITS,
  parameter int unsigned LUT_DEPTH  = DEF_LUT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [PHASE_BITS-1:0] ftw,
  input  logic [LUT_DEPTH-1:0]  phase_offset,
  output logic [LUT_DEPTH-1:0]  lut_addr,
  output logic                  ref_valid,
  output logic                  phase_wrap
);

  logic [PHASE_BITS-1:0]    acc_q, acc_d;
  logic [LUT_DEPTH-1:0]     addr_q, addr_d;
  logic [REF_VALID_DLY-1:0] valid_pipe_q, valid_pipe_d;
  logic [REF_VALID_DLY-1:0] wrap_pipe_q, wrap_pipe_d;
  logic [PHASE_BITS:0]      sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, ftw};
    acc_d  = acc_q;
    addr_d = addr_q;
    if (clear) begin
      acc_d = '0;
    end else if (advance) begin
      // Address comes from the phase before this sample's increment.
      acc_d  = sum[PHASE_BITS-1:0];
      addr_d = acc_q[PHASE_BITS-1 -: LUT_DEPTH] + phase_offset;
    end
    valid_pipe_d = {valid_pipe_q[REF_VALID_DLY-2:0], advance};
    wrap_pipe_d  = {wrap_pipe_q[REF_VALID_DLY-2:0], advance & sum[PHASE_BITS]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      addr_q       <= '0;
      valid_pipe_q <= '0;
      wrap_pipe_q  <= '0;
    end else begin
      acc_q        <= acc_d;
      addr_q       <= addr_d;
      valid_pipe_q <= valid_pipe_d;
      wrap_pipe_q  <= wrap_pipe_d;
    end
  end

  assign lut_addr   = addr_q;
  assign ref_valid  = valid_pipe_q[REF_VALID_DLY-1];
  assign phase_wrap = wrap_pipe_q[REF_VALID_DLY-1];

endmodule

// File: rtl/ddfs_phase_ctrl.sv
// ddfs_phase_ctrl: DDFS controller/sequencer for the lock-in sine/cosine ROM.
// Runs a fixed tone or a stepped linear FTW sweep, one sample per sample_tick.
//   clk, rst_n        : clock, asynchronous active-low reset
//   sample_tick       : one strobe per audio sample
//   cfg_ftw_start/stop/step, cfg_dwell, cfg_phase_offset : latched on cmd_start
//   cmd_start         : latch config and (re)start
//   cmd_stop          : return to IDLE (wins over cmd_start)
//   lut_addr          : ROM address
//   ref_valid         : ROM outputs valid this cycle
//   phase_wrap        : accumulator carry for the sample now valid
//   cur_ftw           : FTW currently applied
//   busy              : in TONE or SWEEP
//   sweep_done        : one-cycle pulse when the sweep reaches its stop FTW
module ddfs_phase_ctrl
  import ddfs_pkg::*;
#(
  parameter int unsigned PHASE_BITS = DEF_PHASE_BITS,
  parameter int unsigned LUT_DEPTH  = DEF_LUT_DEPTH,
  parameter int unsigned DWELL_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [PHASE_BITS-1:0] cfg_ftw_start,
  input  logic [PHASE_BITS-1:0] cfg_ftw_stop,
  input  logic [PHASE_BITS-1:0] cfg_ftw_step,
  input  logic [DWELL_BITS-1:0] cfg_dwell,
  input  logic [LUT_DEPTH-1:0]  cfg_phase_offset,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  output logic [LUT_DEPTH-1:0]  lut_addr,
  output logic                  ref_valid,
  output logic                  phase_wrap,
  output logic [PHASE_BITS-1:0] cur_ftw,
  output logic                  busy,
  output logic                  sweep_done
);

  ddfs_state_e           state_q, state_d;
  logic [PHASE_BITS-1:0] ftw_q, ftw_d;
  logic [PHASE_BITS-1:0] stop_q, stop_d;
  logic [PHASE_BITS-1:0] step_q, step_d;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic [LUT_DEPTH-1:0]  offset_q, offset_d;
  logic [DWELL_BITS-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                  sweep_done_q, sweep_done_d;

  logic                  active;
  logic                  advance;
  logic                  acc_clear;
  logic [PHASE_BITS:0]   nxt_ftw;
  logic [DWELL_BITS-1:0] dwell_last;

  assign active    = (state_q != IDLE);
  // Commands take the cycle; a tick coinciding with one is dropped.
  assign advance   = sample_tick & active & ~cmd_start & ~cmd_stop;
  assign acc_clear = cmd_start | cmd_stop | ~active;

  always_comb begin
    state_d      = state_q;
    ftw_d        = ftw_q;
    stop_d       = stop_q;
    step_d       = step_q;
    dwell_d      = dwell_q;
    offset_d     = offset_q;
    dwell_cnt_d  = dwell_cnt_q;
    sweep_done_d = 1'b0;

    // Extra bit so ftw+step near the top of the range cannot wrap below stop.
    nxt_ftw    = {1'b0, ftw_q} + {1'b0, step_q};
    // A dwell of 0 behaves as 1.
    dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

    if (cmd_stop) begin
      state_d     = IDLE;
      dwell_cnt_d = '0;
    end else if (cmd_start) begin
      stop_d      = cfg_ftw_stop;
      step_d      = cfg_ftw_step;
      dwell_d     = cfg_dwell;
      offset_d    = cfg_phase_offset;
      ftw_d       = cfg_ftw_start;
      dwell_cnt_d = '0;
      if ((cfg_ftw_step == '0) || (cfg_ftw_stop <= cfg_ftw_start)) begin
        state_d = TONE;
      end else begin
        state_d = SWEEP;
      end
    end else if (advance && (state_q == SWEEP)) begin
      if (dwell_cnt_q >= dwell_last) begin
        dwell_cnt_d = '0;
        if (nxt_ftw >= {1'b0, stop_q}) begin
          ftw_d        = stop_q;
          sweep_done_d = 1'b1;
          state_d      = TONE;
        end else begin
          ftw_d = nxt_ftw[PHASE_BITS-1:0];
        end
      end else begin
        dwell_cnt_d = dwell_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ftw_q        <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      offset_q     <= '0;
      dwell_cnt_q  <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ftw_q        <= ftw_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      dwell_q      <= dwell_d;
      offset_q     <= offset_d;
      dwell_cnt_q  <= dwell_cnt_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  ddfs_phase_acc #(
    .PHASE_BITS (PHASE_BITS),
    .LUT_DEPTH  (LUT_DEPTH)
  ) u_phase_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (acc_clear),
    .advance      (advance),
    .ftw          (ftw_q),
    .phase_offset (offset_q),
    .lut_addr     (lut_addr),
    .ref_valid    (ref_valid),
    .phase_wrap   (phase_wrap)
  );

  assign cur_ftw    = ftw_q;
  assign busy       = active;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_ddfs_phase_ctrl.sv
module tb_ddfs_phase_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic [31:0] cfg_ftw_start;
  logic [31:0] cfg_ftw_stop;
  logic [31:0] cfg_ftw_step;
  logic [15:0] cfg_dwell;
  logic [9:0]  cfg_phase_offset;
  logic        cmd_start;
  logic        cmd_stop;
  logic [9:0]  lut_addr;
  logic        ref_valid;
  logic        phase_wrap;
  logic [31:0] cur_ftw;
  logic        busy;
  logic        sweep_done;

  int n_checks = 0;
  int n_bad    = 0;

  ddfs_phase_ctrl #(
    .PHASE_BITS (32),
    .LUT_DEPTH  (10),
    .DWELL_BITS (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_tick      (sample_tick),
    .cfg_ftw_start    (cfg_ftw_start),
    .cfg_ftw_stop     (cfg_ftw_stop),
    .cfg_ftw_step     (cfg_ftw_step),
    .cfg_dwell        (cfg_dwell),
    .cfg_phase_offset (cfg_phase_offset),
    .cmd_start        (cmd_start),
    .cmd_stop         (cmd_stop),
    .lut_addr         (lut_addr),
    .ref_valid        (ref_valid),
    .phase_wrap       (phase_wrap),
    .cur_ftw          (cur_ftw),
    .busy             (busy),
    .sweep_done       (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] f0, input logic [31:0] f1,
                          input logic [31:0] fs, input logic [15:0] dw,
                          input logic [9:0] off);
    cfg_ftw_start    = f0;
    cfg_ftw_stop     = f1;
    cfg_ftw_step     = fs;
    cfg_dwell        = dw;
    cfg_phase_offset = off;
    cmd_start        = 1'b1;
    step_cyc();
    cmd_start        = 1'b0;
  endtask

  task automatic do_stop();
    cmd_stop = 1'b1;
    step_cyc();
    cmd_stop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".lut_addr"},   64'(lut_addr),   64'd0);
    check_eq({tag, ".ref_valid"},  64'(ref_valid),  64'd0);
    check_eq({tag, ".phase_wrap"}, 64'(phase_wrap), 64'd0);
    check_eq({tag, ".cur_ftw"},    64'(cur_ftw),    64'd0);
    check_eq({tag, ".busy"},       64'(busy),       64'd0);
    check_eq({tag, ".sweep_done"}, 64'(sweep_done), 64'd0);
  endtask

  // Sweep 0x40_0000 -> 0x100_0000, step 0x40_0000, dwell 4, offset 0:
  // address after tick k (k=1..16), hand-accumulated top-10 phase bits.
  int sw_addr [16] = '{0, 1, 2, 3, 4, 6, 8, 10, 12, 15, 18, 21, 24, 28, 32, 36};
  logic [31:0] sw_ftw [16] = '{32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0080_0000,
                               32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h00C0_0000,
                               32'h00C0_0000, 32'h00C0_0000, 32'h00C0_0000, 32'h0100_0000,
                               32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000};

  initial begin
    rst_n            = 1'b0;
    sample_tick      = 1'b0;
    cfg_ftw_start    = '0;
    cfg_ftw_stop     = '0;
    cfg_ftw_step     = '0;
    cfg_dwell        = '0;
    cfg_phase_offset = '0;
    cmd_start        = 1'b0;
    cmd_stop         = 1'b0;

    // Reset state and idle behaviour
    step_cyc();
    step_cyc();
    check_all_zero("reset");
    rst_n = 1'b1;
    sample_tick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_cyc();
      check_eq("idle.ref_valid", 64'(ref_valid), 64'd0);
      check_eq("idle.busy",      64'(busy),      64'd0);
    end
    sample_tick = 1'b0;

    // Fixed tone, ftw 0x0100_0000 -> address step 4
    do_start(32'h0100_0000, 32'h0, 32'h0, 16'd0, 10'd0);
    check_eq("tone.busy",      64'(busy),      64'd1);
    check_eq("tone.cur_ftw",   64'(cur_ftw),   64'h0100_0000);
    check_eq("tone.ref_valid0",64'(ref_valid), 64'd0);
    sample_tick = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      step_cyc();
      check_eq("tone.addr",  64'(lut_addr),   64'((4 * (k - 1)) % 1024));
      check_eq("tone.valid", 64'(ref_valid),  64'(k >= 2));
      check_eq("tone.wrap",  64'(phase_wrap), 64'(k == 257));
    end
    // Stop with a tick pending: in-flight sample still emits, nothing new
    do_stop();
    check_eq("stop.busy",      64'(busy),      64'd0);
    check_eq("stop.inflight",  64'(ref_valid), 64'd1);
    check_eq("stop.addr_hold", 64'(lut_addr),  64'd12);
    step_cyc();
    check_eq("stop.drained",   64'(ref_valid), 64'd0);
    check_eq("stop.addr_hold2",64'(lut_addr),  64'd12);
    sample_tick = 1'b0;

    // Tone with phase offset 256; address wraps 1020 -> 0
    do_start(32'h0100_0000, 32'h0, 32'h0, 16'd0, 10'd256);
    sample_tick = 1'b1;
    for (int k = 1; k <= 194; k++) begin
      step_cyc();
      check_eq("offs.addr", 64'(lut_addr), 64'((256 + 4 * (k - 1)) % 1024));
    end
    sample_tick = 1'b0;
    do_stop();

    // Stepped sweep with dwell 4
    do_start(32'h0040_0000, 32'h0100_0000, 32'h0040_0000, 16'd4, 10'd0);
    check_eq("sweep.cur_ftw0", 64'(cur_ftw), 64'h0040_0000);
    check_eq("sweep.busy0",    64'(busy),    64'd1);
    sample_tick = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step_cyc();
      check_eq("sweep.addr", 64'(lut_addr),   64'(sw_addr[k-1]));
      check_eq("sweep.ftw",  64'(cur_ftw),    64'(sw_ftw[k-1]));
      check_eq("sweep.done", 64'(sweep_done), 64'(k == 12));
    end
    check_eq("sweep.end_busy", 64'(busy), 64'd1);
    sample_tick = 1'b0;
    do_stop();

    // Clamp at stop, dwell 0 behaves as 1
    do_start(32'h0040_0000, 32'h0100_0000, 32'h0080_0000, 16'd0, 10'd0);
    sample_tick = 1'b1;
    step_cyc();
    check_eq("clamp.ftw1",  64'(cur_ftw),    64'h00C0_0000);
    check_eq("clamp.done1", 64'(sweep_done), 64'd0);
    step_cyc();
    check_eq("clamp.ftw2",  64'(cur_ftw),    64'h0100_0000);
    check_eq("clamp.done2", 64'(sweep_done), 64'd1);
    step_cyc();
    check_eq("clamp.ftw3",  64'(cur_ftw),    64'h0100_0000);
    check_eq("clamp.done3", 64'(sweep_done), 64'd0);
    check_eq("clamp.busy",  64'(busy),       64'd1);
    sample_tick = 1'b0;
    do_stop();

    // ftw+step overflows 32 bits: must still clamp to stop
    do_start(32'hF000_0000, 32'hFFFF_FFFF, 32'h2000_0000, 16'd1, 10'd0);
    sample_tick = 1'b1;
    step_cyc();
    check_eq("ovf.ftw",  64'(cur_ftw),    64'hFFFF_FFFF);
    check_eq("ovf.done", 64'(sweep_done), 64'd1);

    // cmd_start and cmd_stop together: stop wins
    sample_tick = 1'b0;
    cmd_start = 1'b1;
    cmd_stop  = 1'b1;
    step_cyc();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    check_eq("race.busy", 64'(busy), 64'd0);

    // Restart mid-sweep: accumulator restarts, new FTW and offset apply
    do_start(32'h0040_0000, 32'h0100_0000, 32'h0040_0000, 16'd4, 10'd0);
    sample_tick = 1'b1;
    for (int k = 0; k < 6; k++) step_cyc();
    check_eq("restart.pre_addr", 64'(lut_addr), 64'd6);
    do_start(32'h0200_0000, 32'h1000_0000, 32'h0100_0000, 16'd2, 10'd100);
    check_eq("restart.ftw0",  64'(cur_ftw),  64'h0200_0000);
    check_eq("restart.busy",  64'(busy),     64'd1);
    step_cyc();
    check_eq("restart.addr1", 64'(lut_addr), 64'd100);
    step_cyc();
    check_eq("restart.addr2", 64'(lut_addr), 64'd108);
    check_eq("restart.ftw2",  64'(cur_ftw),  64'h0300_0000);
    step_cyc();
    check_eq("restart.addr3", 64'(lut_addr), 64'd116);
    check_eq("restart.valid", 64'(ref_valid),64'd1);

    // Asynchronous reset mid-run: outputs clear with no clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sample_tick = 1'b0;
    #20;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/ddfs_phase_ctrl.md
Name: ddfs_phase_ctrl

Overview:
Controller and sequencer for the lock-in DDFS sine/cosine ROM.
- Owns the phase accumulator and frequency tuning word (FTW); drives the ROM address once per audio sample.
- Runs either a fixed reference tone or a stepped linear frequency sweep.
- Emits ref_valid aligned with the ROM's 1-cycle registered read, so the demodulator multipliers consume sine/cosine directly.

Parameters:
PHASE_BITS, 32, phase accumulator / FTW width.
LUT_DEPTH, 10, ROM address width; must match the ROM instance.
DWELL_BITS, 16, width of the per-step dwell counter, in samples.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
sample_tick  in  1  one-cycle strobe, one per audio sample.
cfg_ftw_start  in  PHASE_BITS  initial FTW, unsigned.
cfg_ftw_stop  in  PHASE_BITS  final sweep FTW, unsigned.
cfg_ftw_step  in  PHASE_BITS  FTW increment per dwell; 0 selects fixed tone.
cfg_dwell  in  DWELL_BITS  samples per sweep step; 0 is treated as 1.
cfg_phase_offset  in  LUT_DEPTH  added to the ROM address (reference phase trim).
cmd_start  in  1  pulse: latch cfg_* and (re)start.
cmd_stop  in  1  pulse: return to IDLE.
lut_addr  out  LUT_DEPTH  ROM address.
ref_valid  out  1  pulse: ROM sine/cosine outputs are a valid sample this cycle.
phase_wrap  out  1  pulse aligned with ref_valid; accumulator carried out on this sample.
cur_ftw  out  PHASE_BITS  FTW currently applied.
busy  out  1  high in TONE or SWEEP.
sweep_done  out  1  one-cycle pulse when the sweep reaches cfg_ftw_stop.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; accumulator, dwell counter and tick pipeline cleared.
  - All outputs 0.
- States:
  - IDLE: accumulator held at 0; sample_tick ignored; busy=0.
  - cmd_start in any state: latch all cfg_*; acc<=0; ftw<=cfg_ftw_start; dwell_cnt<=0.
    - Go to TONE if cfg_ftw_step==0 or cfg_ftw_stop<=cfg_ftw_start.
    - Otherwise go to SWEEP.
  - TONE: each sample_tick advances the accumulator; the FTW is constant. cmd_stop goes to IDLE.
  - SWEEP: each sample_tick advances the accumulator and increments dwell_cnt.
    - When dwell_cnt reaches max(cfg_dwell,1)-1 on a tick: dwell_cnt<=0 and nxt=ftw+step, computed at PHASE_BITS+1 bits.
    - If nxt>=stop: ftw<=stop, pulse sweep_done next cycle, go to TONE (holds at stop frequency).
    - Otherwise ftw<=nxt.
    - cmd_stop goes to IDLE.
- cmd_stop and cmd_start in the same cycle: stop wins, state goes to IDLE.
- Tick cycle n in TONE/SWEEP, evaluated at the clock edge ending cycle n:
  - lut_addr <= acc[PHASE_BITS-1 -: LUT_DEPTH] + cfg_phase_offset, modulo 2^LUT_DEPTH.
  - acc <= acc + ftw, modulo 2^PHASE_BITS; the ftw used is the value registered before the tick.
  - First sample after start therefore addresses the phase offset; with offset 0 this is sine 0.
- Latency:
  - lut_addr updates at cycle n+1.
  - ROM data and ref_valid are valid at cycle n+2.
  - phase_wrap uses the same 2-stage delay as ref_valid.
- An FTW change takes effect on the tick after it is registered, so frequency changes are phase-continuous.
- In-flight samples at cmd_stop still emit their ref_valid. No new samples issue after IDLE is entered.
- lut_addr holds its last value while idle.
- Back-to-back ticks on every cycle are fully supported; there is no throughput limit.

Decomposition:
- Shared package ddfs_pkg:
  - state encoding: IDLE=0, TONE=1, SWEEP=2.
  - default PHASE_BITS and LUT_DEPTH.
  - helper localparam for the 2-cycle ROM-aligned valid delay.
- One sub-module, ddfs_phase_acc:
  - accumulator, address truncate + offset register, carry-out.
  - tick/wrap 2-stage delay line.
- FSM, sweep arithmetic and dwell counter stay in the top level.
- ddfs_sine_lut is instantiated by the parent, not inside this block.

Test Plan (PHASE_BITS=32, LUT_DEPTH=10):
1. Reset: assert rst_n=0 mid-run → all outputs 0 immediately, without a clock edge. sample_tick in IDLE → no ref_valid.
2. Tone: start=0x0100_0000, step=0, offset=0, tick every cycle → lut_addr 0,4,8,…; ref_valid 2 cycles after each tick; phase_wrap on the sample after 256 ticks; busy=1.
3. Offset: same tone with offset=256 → lut_addr 256,260,…; at 1020 the address wraps to 0 (1020+4).
4. Sweep: start=0x0040_0000, stop=0x0100_0000, step=0x0040_0000, dwell=4 → cur_ftw 0x40_0000, 0x80_0000, 0xC0_0000, 0x100_0000, changing every 4 ticks; sweep_done pulses once; state ends in TONE.
5. Clamp: start=0x0040_0000, step=0x0080_0000, stop=0x0100_0000, dwell=0 → cur_ftw 0x00C0_0000 then 0x0100_0000 on consecutive ticks; sweep_done pulses.
6. Control races: cmd_start+cmd_stop same cycle → IDLE, busy=0. cmd_start mid-sweep → acc restarts, next address = offset, ftw = new start.
